// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Fetch-stage bus bundle: instruction-memory req/ack port and
//               the decode-facing valid/ready plus branch redirect port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_disp;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc, redirect_disp
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, id_ready, redirect_valid, redirect_pc, redirect_disp
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : SPARC fetch stage: PC, single-outstanding imem fetch, prefetch
//               FIFO toward decode, and taken-branch redirect/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    instruction_fetch_if.master   bus
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_pc, w_pc_nxt;
    logic [31:0]          r_addr, w_addr_nxt;
    logic                 w_push, w_pop;
    logic [31:0]          w_disp_sum, w_target, w_pc_inc;
    logic [1:0]           w_unused_disp_hi;

    logic [31:0]          r_fifo_instr [DEPTH];
    logic [31:0]          r_fifo_pc    [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr, r_wr_ptr, w_rd_ptr_nxt;
    logic [c_CNT_W-1:0]   r_count, w_count_pop, w_count_nxt;
    logic                 r_if_valid;
    logic [31:0]          r_if_instr, r_if_pc;

    // Displacement is a word count, so only its low 30 bits reach the byte address.
    assign w_disp_sum       = bus.redirect_pc + {bus.redirect_disp[29:0], 2'b00};
    assign w_target         = {w_disp_sum[31:2], 2'b00};
    assign w_unused_disp_hi = bus.redirect_disp[31:30];
    assign w_pc_inc         = r_pc + 32'd4;

    // A redirect flushes the FIFO, so a same-cycle pop is discarded.
    assign w_pop        = r_if_valid & bus.id_ready & ~bus.redirect_valid;
    assign w_count_pop  = r_count - c_CNT_W'(w_pop);
    assign w_count_nxt  = w_count_pop + c_CNT_W'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);

    assign bus.imem_req  = (r_state != S_IDLE);
    assign bus.imem_addr = r_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_addr_nxt  = w_target;
                    w_state_nxt = S_REQ;
                end else if (r_count < c_DEPTH) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_target;
                    if (bus.imem_ack) begin
                        w_addr_nxt  = w_target;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else if (bus.imem_ack) begin
                    w_push   = 1'b1;
                    w_pc_nxt = w_pc_inc;
                    // Issue back-to-back only if the next word still fits after this push.
                    if ((w_count_pop + c_CNT_ONE) < c_DEPTH) begin
                        w_addr_nxt = w_pc_inc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_target;
                end
                if (bus.imem_ack) begin
                    w_addr_nxt  = bus.redirect_valid ? w_target : r_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            if (bus.redirect_valid) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_if_valid <= 1'b0;
            end else begin
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(w_push);
                r_count    <= w_count_nxt;
                r_if_valid <= (w_count_nxt != '0);
                // Head registers bypass the array when the push lands in an empty FIFO.
                if (w_push && (w_count_pop == '0)) begin
                    r_if_instr <= bus.imem_rdata;
                    r_if_pc    <= r_pc;
                end else if (w_pop && (w_count_pop != '0)) begin
                    r_if_instr <= r_fifo_instr[w_rd_ptr_nxt];
                    r_if_pc    <= r_fifo_pc[w_rd_ptr_nxt];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch: directed phases push
//               expected addresses/outputs, monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();
    instruction_fetch_if wbus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus.master)
    );

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    bit          mem_en = 1'b0;
    logic [31:0] exp_out [$];
    logic [31:0] exp_addr [$];
    logic [31:0] mon_pc, mon_addr;
    bit          req_prev = 1'b0;
    bit          ack_prev = 1'b0;
    int          cnt = 0;
    int          widx = 0;
    logic [31:0] wexp [3];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n, input bit to_addr, input bit to_out);
        for (int i = 0; i < n; i++) begin
            if (to_addr) exp_addr.push_back(base + 32'(4 * i));
            if (to_out)  exp_out.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst                = 1'b1;
        chk_en             = 1'b0;
        mem_en             = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0;
        exp_out.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.imem_req) begin
            total++;
            bad++;
            $display("FAIL %s: imem_req got 0 expected 1", name);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_out.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_out.size() != 0) begin
            bad++;
            $display("FAIL %s_out_drain: got %0d outputs pending expected 0", name, exp_out.size());
        end
        total++;
        if (exp_addr.size() != 0) begin
            bad++;
            $display("FAIL %s_addr_drain: got %0d requests pending expected 0", name, exp_addr.size());
        end
        #1;
        chk_en       = 1'b0;
        bus.id_ready = 1'b0;
    endtask

    // Output monitor: a beat is consumed when valid & ready and no redirect.
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst && bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
            if (exp_out.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: got pc %h expected none", bus.if_pc);
            end else begin
                mon_pc = exp_out.pop_front();
                check("out_pc", bus.if_pc, mon_pc);
                check("out_instr", bus.if_instr, word_of(mon_pc));
            end
        end
    end

    // Request monitor: a new request starts when req rises or follows an ack.
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst && bus.imem_req && (!req_prev || ack_prev) && exp_addr.size() != 0) begin
            mon_addr = exp_addr.pop_front();
            check("req_addr", bus.imem_addr, mon_addr);
        end
        req_prev = bus.imem_req && !rst;
        ack_prev = bus.imem_ack;
    end

    // Memory model: ack one cycle after each request is first seen.
    initial forever begin
        @(posedge clk); #3;
        if (mem_en) begin
            if (rst) begin
                bus.imem_ack = 1'b0;
                cnt          = 0;
            end else if (bus.imem_ack) begin
                bus.imem_ack = 1'b0;
                cnt          = bus.imem_req ? 1 : 0;
            end else if (bus.imem_req) begin
                if (cnt >= 1) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = word_of(bus.imem_addr);
                end else begin
                    cnt = 1;
                end
            end
        end else begin
            cnt = 0;
        end
    end

    // Wrap instance: first three fetch addresses after reset.
    initial begin
        wexp[0]             = 32'hFFFF_FFF8;
        wexp[1]             = 32'hFFFF_FFFC;
        wexp[2]             = 32'h0000_0000;
        wbus.imem_ack       = 1'b0;
        wbus.imem_rdata     = '0;
        wbus.id_ready       = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;
        wbus.redirect_disp  = '0;
        forever begin
            @(posedge clk); #3;
            if (wbus.imem_ack) begin
                wbus.imem_ack = 1'b0;
            end else if (wbus.imem_req && !rst) begin
                if (widx < 3) begin
                    check("wrap_addr", wbus.imem_addr, wexp[widx]);
                    widx++;
                end
                wbus.imem_ack   = 1'b1;
                wbus.imem_rdata = 32'(widx);
            end
        end
    end

    initial begin
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.redirect_disp  = '0;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_instr", bus.if_instr, 32'h0);
        check("rst_pc", bus.if_pc, 32'h0);

        // Streaming with decode always ready
        @(posedge clk); #1;
        bus.id_ready = 1'b1;
        push_seq(32'h0, 8, 1'b1, 1'b1);
        chk_en = 1'b1;
        mem_en = 1'b1;
        rst    = 1'b0;
        wait_drain("stream", 200);

        // Backpressure: exactly two words buffered, then resume at pc=8
        do_reset();
        push_seq(32'h0, 2, 1'b1, 1'b0);
        chk_en = 1'b1;
        mem_en = 1'b1;
        rst    = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_req_idle", 32'(bus.imem_req), 32'd0);
        check("bp_valid", 32'(bus.if_valid), 32'd1);
        check("bp_head_pc", bus.if_pc, 32'h0);
        @(posedge clk); #1;
        push_seq(32'h8, 2, 1'b1, 1'b0);
        push_seq(32'h0, 4, 1'b0, 1'b1);
        bus.id_ready = 1'b1;
        wait_drain("backpressure", 200);

        // Redirect with a request outstanding: late ack data is dropped
        do_reset();
        bus.id_ready = 1'b1;
        exp_addr.push_back(32'h0);
        push_seq(32'hF8, 2, 1'b1, 1'b1);
        chk_en = 1'b1;
        rst    = 1'b0;
        wait_req("drop_wait_req");
        @(posedge clk); #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        bus.redirect_disp  = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("drop_req", 32'(bus.imem_req), 32'd1);
        check("drop_hold_addr", bus.imem_addr, 32'h0);
        @(posedge clk); #1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_0000;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        mem_en       = 1'b1;
        wait_drain("drop", 200);

        // Redirect coinciding with ack and pop
        do_reset();
        push_seq(32'h0, 2, 1'b1, 1'b0);
        push_seq(32'h20C, 2, 1'b1, 1'b1);
        chk_en = 1'b1;
        rst    = 1'b0;
        wait_req("rd_wait_req");
        @(posedge clk); #1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word_of(32'h0);
        @(posedge clk); #1;
        bus.imem_rdata     = word_of(32'h4);
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.redirect_disp  = 32'h0000_0003;
        @(posedge clk); #1;
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_flush_valid", 32'(bus.if_valid), 32'd0);
        check("rd_req", 32'(bus.imem_req), 32'd1);
        check("rd_target_addr", bus.imem_addr, 32'h0000_020C);
        @(posedge clk); #1;
        mem_en = 1'b1;
        wait_drain("redirect_ack", 200);

        // Reset during an outstanding request with an ack in the reset cycle
        bus.id_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mem_en       = 1'b0;
        bus.imem_ack = 1'b0;
        wait_req("mid_wait_req");
        @(posedge clk); #1;
        rst            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check("mid_rst_addr", bus.imem_addr, 32'h0);
        check("mid_rst_valid", 32'(bus.if_valid), 32'd0);
        check("mid_rst_instr", bus.if_instr, 32'h0);
        check("mid_rst_pc", bus.if_pc, 32'h0);
        @(posedge clk); #1;
        exp_out.delete();
        exp_addr.delete();
        push_seq(32'h0, 2, 1'b1, 1'b1);
        chk_en = 1'b1;
        mem_en = 1'b1;
        rst    = 1'b0;
        wait_drain("mid_reset", 200);

        total++;
        if (widx != 3) begin
            bad++;
            $display("FAIL wrap_count: got %0d wrap fetches expected 3", widx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
